// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types and helpers for the MEM-stage load/store unit:
//            FSM state encoding, request size encodings and the legality check.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  // Alignment and encoding check. Unsigned sizes only exist for loads.
  function automatic logic is_legal(input logic       we,
                                    input logic [2:0] size,
                                    input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lo[0] == 1'b0);
      SZ_W:    ok = (addr_lo == 2'b00);
      SZ_BU:   ok = !we;
      SZ_HU:   ok = !we && (addr_lo[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane
// Purpose  : Combinational big-endian byte-lane logic. Extracts and extends
//            load data from a memory word, and merges sub-word store data
//            into a previously read word.
// Ports    : word        in  32  word read from memory
//            offset      in  2   byte offset inside the word
//            size        in  3   request size encoding
//            wdata       in  32  right-justified store data
//            load_data   out 32  sign/zero-extended load result
//            merged_word out 32  word to write back for the store
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Big-endian: offset 0 is the most significant byte.
  always_comb begin
    lane_byte = word[31:24];
    case (offset)
      2'd0: lane_byte = word[31:24];
      2'd1: lane_byte = word[23:16];
      2'd2: lane_byte = word[15:8];
      2'd3: lane_byte = word[7:0];
      default: lane_byte = word[31:24];
    endcase
    lane_half = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      SZ_BU:   load_data = {24'h0, lane_byte};
      SZ_H:    load_data = {{16{lane_half[15]}}, lane_half};
      SZ_HU:   load_data = {16'h0, lane_half};
      SZ_W:    load_data = word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    merged_word = word;
    case (size)
      SZ_B: begin
        case (offset)
          2'd0: merged_word[31:24] = wdata[7:0];
          2'd1: merged_word[23:16] = wdata[7:0];
          2'd2: merged_word[15:8]  = wdata[7:0];
          2'd3: merged_word[7:0]   = wdata[7:0];
          default: merged_word = word;
        endcase
      end
      SZ_H: begin
        if (offset[1]) merged_word[15:0]  = wdata[15:0];
        else           merged_word[31:16] = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage load/store unit. Turns byte/halfword/word requests into
//            word accesses on a big-endian, word-indexed data memory, using
//            read-modify-write for sub-word stores.
// Ports    : clk, rst_n                  clock, async active-low reset
//            req_valid/req_ready         request handshake
//            req_we, req_size            store flag, size encoding
//            req_addr, req_wdata         byte address, store data
//            resp_valid/resp_rdata/err   one-cycle completion
//            MemRead, MemWrite           memory strobes
//            mem_address                 word index
//            mem_write_data              word to write
//            mem_read_data               combinational word from memory
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_t        state, next_state;

  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [31:0]       wbuf_q;

  logic              accept;
  logic              legal;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  assign accept = (state == ST_IDLE) && req_valid;
  assign legal  = is_legal(req_we, req_size, req_addr[1:0]);

  lsu_lane u_lane (
    .word        (mem_read_data),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!legal)                          next_state = ST_RESP;
          else if (req_we && req_size == SZ_W) next_state = ST_WRITE;
          else                                 next_state = ST_READ;
        end
      end
      ST_READ:  next_state = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE: next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Request capture and read-word capture. A word store skips READ, so its
  // data goes straight into the write buffer at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wbuf_q  <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= !legal;
      rdata_q <= '0;
      wbuf_q  <= 32'(req_wdata);
    end else if (state == ST_READ) begin
      if (we_q) wbuf_q  <= merged_word;
      else      rdata_q <= DATA_W'(load_data);
    end
  end

  // Outputs; bus fields are forced to zero whenever no access is in flight.
  always_comb begin
    req_ready      = (state == ST_IDLE);
    MemRead        = (state == ST_READ);
    MemWrite       = (state == ST_WRITE);
    resp_valid     = (state == ST_RESP);
    resp_err       = (state == ST_RESP) && err_q;
    resp_rdata     = (state == ST_RESP) ? rdata_q : '0;
    mem_address    = 32'h0;
    mem_write_data = 32'h0;
    if (state == ST_READ || state == ST_WRITE)
      mem_address = 32'(addr_q[ADDR_W-1:2]);
    if (state == ST_WRITE)
      mem_write_data = wbuf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit with a small
//            behavioural word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];

  int total;
  int bad;

  // Per-request observations
  int          lat;
  int          nrd;
  int          nwr;
  int          both;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] got_rdata;
  logic        got_err;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = MemRead ? mem[mem_address[5:0]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, then watch up to 10 cycles for the response.
  // Memory writes are applied here when MemWrite is seen.
  task automatic issue(input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    @(negedge clk);
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; both = 0; got = 1'b0;
    rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0;
    got_rdata = 32'hxxxx_xxxx; got_err = 1'bx;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (MemRead) begin
        nrd++;
        rd_addr = mem_address;
      end
      if (MemWrite) begin
        nwr++;
        wr_addr = mem_address;
        wr_data = mem_write_data;
        mem[mem_address[5:0]] = mem_write_data;
      end
      if (MemRead && MemWrite) both++;
      if (resp_valid) begin
        got       = 1'b1;
        lat       = i;
        got_rdata = resp_rdata;
        got_err   = resp_err;
      end
    end
  endtask

  initial begin
    int accepts;
    int resps;
    int acc_cyc[2];
    int consec;
    logic prev_resp;

    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    rst_n = 1'b0;

    // ---- Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_outs", {26'h0, resp_valid, resp_err, MemRead, MemWrite, 2'b00}, 32'h0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_wdata", mem_write_data, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'h0, req_ready}, 32'h1);

    // ---- Word round trip
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    check("sw_lat", lat, 2);
    check("sw_nwr", nwr, 1);
    check("sw_nrd", nrd, 0);
    check("sw_addr", wr_addr, 32'h4);
    check("sw_data", wr_data, 32'hDEADBEEF);
    check("sw_err", {31'h0, got_err}, 32'h0);
    check("sw_rdata", got_rdata, 32'h0);
    issue(1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_lat", lat, 2);
    check("lw_nrd", nrd, 1);
    check("lw_addr", rd_addr, 32'h4);
    check("lw_rdata", got_rdata, 32'hDEADBEEF);

    // ---- Signed / unsigned sub-word loads
    mem[4] = 32'h1280_FF7F;
    issue(1'b0, 3'd0, 32'h11, 32'h0); check("lb_11", got_rdata, 32'hFFFF_FF80);
    issue(1'b0, 3'd4, 32'h11, 32'h0); check("lbu_11", got_rdata, 32'h0000_0080);
    issue(1'b0, 3'd0, 32'h13, 32'h0); check("lb_13", got_rdata, 32'h0000_007F);
    issue(1'b0, 3'd0, 32'h10, 32'h0); check("lb_10", got_rdata, 32'h0000_0012);
    issue(1'b0, 3'd5, 32'h12, 32'h0); check("lhu_12", got_rdata, 32'h0000_FF7F);
    issue(1'b0, 3'd1, 32'h12, 32'h0); check("lh_12", got_rdata, 32'hFFFF_FF7F);
    issue(1'b0, 3'd1, 32'h10, 32'h0); check("lh_10", got_rdata, 32'h0000_1280);
    check("lh_lat", lat, 2);

    // ---- Sub-word store merges
    mem[4] = 32'h1122_3344;
    issue(1'b1, 3'd0, 32'h12, 32'h0000_00AB);
    check("sb_lat", lat, 3);
    check("sb_nrd", nrd, 1);
    check("sb_nwr", nwr, 1);
    check("sb_both", both, 0);
    check("sb_wdata", wr_data, 32'h1122_AB44);
    issue(1'b0, 3'd2, 32'h10, 32'h0); check("sb_readback", got_rdata, 32'h1122_AB44);
    issue(1'b1, 3'd1, 32'h10, 32'hFFFF_5566);
    check("sh_wdata", wr_data, 32'h5566_AB44);
    issue(1'b1, 3'd0, 32'h13, 32'h0000_0099);
    check("sb13_wdata", wr_data, 32'h5566_AB99);

    // ---- Misalignment / illegal sizes
    issue(1'b0, 3'd2, 32'h12, 32'h0);
    check("lw_mis_err", {31'h0, got_err}, 32'h1);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_bus", nrd + nwr, 0);
    check("lw_mis_rdata", got_rdata, 32'h0);
    issue(1'b1, 3'd1, 32'h13, 32'h0000_7777);
    check("sh_mis_err", {31'h0, got_err}, 32'h1);
    check("sh_mis_bus", nrd + nwr, 0);
    check("sh_mis_mem", mem[4], 32'h5566_AB99);
    issue(1'b1, 3'd4, 32'h10, 32'h0);
    check("sbu_err", {31'h0, got_err}, 32'h1);
    issue(1'b0, 3'd3, 32'h10, 32'h0);
    check("sz3_err", {31'h0, got_err}, 32'h1);
    issue(1'b0, 3'd5, 32'h11, 32'h0);
    check("lhu_mis_err", {31'h0, got_err}, 32'h1);

    // ---- Address wrap
    mem[63] = 32'hCAFE_F00D;
    issue(1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0);
    check("wrap_addr", rd_addr, 32'h3FFF_FFFF);
    check("wrap_rdata", got_rdata, 32'hCAFE_F00D);
    check("wrap_err", {31'h0, got_err}, 32'h0);

    // ---- Reset during the READ of an SB
    mem[4] = 32'h1122_3344;
    @(negedge clk);
    req_we = 1'b1; req_size = 3'd0; req_addr = 32'h12; req_wdata = 32'hAB;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_read", {31'h0, MemRead}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rd_drop", {31'h0, MemRead}, 32'h0);
    check("mid_addr", mem_address, 32'h0);
    check("mid_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    nwr = 0; resps = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (MemWrite) nwr++;
      if (resp_valid) resps++;
    end
    check("mid_no_resp", resps, 0);
    check("mid_no_wr", nwr, 0);
    check("mid_ready2", {31'h0, req_ready}, 32'h1);
    check("mid_mem", mem[4], 32'h1122_3344);

    // ---- Back-to-back loads with req_valid held
    @(negedge clk);
    req_we = 1'b0; req_size = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1;
    accepts = 0; resps = 0; consec = 0; prev_resp = 1'b0;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        resps++;
        if (prev_resp) consec++;
      end
      prev_resp = resp_valid;
      if (req_ready && req_valid) begin
        acc_cyc[accepts] = c;
        accepts++;
      end
      @(posedge clk);
      #1;
      if (accepts == 2) req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_accepts", accepts, 2);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 3);
    check("b2b_resps", resps, 2);
    check("b2b_consec", consec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit in the MEM stage of the MIPS datapath, directly upstream of `data_memory`. It accepts one load or store request from the EX/MEM register and converts byte and halfword accesses into word accesses. Sub-word stores use read-modify-write. It returns load data sign- or zero-extended to the writeback path. Memory is big-endian and word-indexed: `data_memory` address N holds bytes 4N..4N+3.

## Interface
- `ADDR_W`, 32: byte-address width of requests.
- `DATA_W`, 32: data width; fixed at 32.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  3  0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU. Stores use only 0/1/2.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned address or illegal size; valid with `resp_valid`.
- `MemRead`  out  1  to `data_memory`.
- `MemWrite`  out  1  to `data_memory`.
- `mem_address`  out  32  word index, `req_addr[ADDR_W-1:2]` zero-extended.
- `mem_write_data`  out  32  word to write.
- `mem_read_data`  in  32  word from `data_memory`. It is combinational from `mem_address` while `MemRead`=1.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_size`, `req_addr`, `req_wdata`.
  - Error check: H/HU with `addr[0]`≠0, W with `addr[1:0]`≠0, or size ∉ {0,1,2,4,5}. A store with size 4 or 5 is illegal. Any error goes to RESP with err=1 and no memory access.
  - LW/LB/LH/LBU/LHU and SB/SH go to READ; SW goes to WRITE.
- **READ**
  - `MemRead`=1 and `mem_address` driven; the word is captured at the clock edge.
  - Loads go to RESP.
  - SB/SH go to WRITE with the merged word.
- **WRITE**
  - `MemWrite`=1 for exactly one cycle, with `mem_address` and `mem_write_data` driven; then go to RESP.
- **RESP**
  - `resp_valid`=1 for one cycle, then go to IDLE.
  - No backpressure: the pipeline must sample `resp_valid` in that cycle.
- Byte lanes, big-endian:
  - Byte offset k uses bits [31-8k : 24-8k].
  - Half offset 0 uses [31:16]; half offset 2 uses [15:0].
  - Extraction: B/H sign-extend from the lane MSB; BU/HU zero-extend.
  - Merge: replace only the addressed lane with `wdata[7:0]` or `wdata[15:0]`; all other bits keep the read word.
- `MemRead` and `MemWrite` are never both 1.
- `mem_address` and `mem_write_data` are 0 when the bus is idle.

## Timing
- Reset values: state IDLE, `req_ready`=1; `resp_valid`, `resp_err`, `MemRead` and `MemWrite` all 0; `resp_rdata`, `mem_address` and `mem_write_data` all 0.
- Latency from the acceptance edge to `resp_valid`:
  - loads: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - errors: 1 cycle
- Back-to-back requests: the next request is accepted in the cycle after RESP, giving a throughput of 1 per 3 cycles (loads/SW).
- `req_valid` while not in IDLE is ignored; the requester must hold it until `req_ready`.
- Async reset mid-operation:
  - All outputs return to reset values immediately; the request is dropped with no response.
  - A store reset during WRITE may or may not have written; memory is never partially merged.
- Address wrap: 0xFFFF_FFFC is a legal word access at index 0x3FFF_FFFF.

## Structure
- `lsu_pkg`:
  - FSM state enum.
  - `req_size` encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU).
  - Function `is_legal(we, size, addr_lo)`.
- Sub-module `lsu_lane`: combinational extract/extend and merge from (word, offset, size, wdata). Keeps the FSM module under ~200 lines.

## Test plan
- Word round trip: SW addr 0x10 data 0xDEADBEEF; then LW 0x10. Expect `mem_address`=4, one `MemWrite` pulse, and `resp_rdata`=0xDEADBEEF after 2 cycles.
- Signed/unsigned byte loads: with word 4 = 0x1280_FF7F:
  - LB 0x11 → 0xFFFF_FF80
  - LBU 0x11 → 0x0000_0080
  - LB 0x13 → 0x0000_007F
  - LHU 0x12 → 0x0000_FF7F
- SB merge: word 4 = 0x11223344, SB 0x12 data 0xAB. Expect READ then WRITE of 0x1122AB44, and LW 0x10 = 0x1122AB44.
- Misalignment:
  - LW 0x12 → `resp_err`=1 one cycle after acceptance, no `MemRead`/`MemWrite`.
  - SH 0x13 → error; memory unchanged.
- Reset mid-SB: assert `rst_n`=0 during READ. Expect `MemRead` to drop immediately, no `resp_valid`, `req_ready`=1 after release, and word 4 unchanged.
- Back-to-back: LW with `req_valid` held. The second request is accepted exactly 3 cycles after the first; `resp_valid` is never high in consecutive cycles.
